// File: rtl/rtp_pkg.sv
// rtp_pkg: RTP constants, header byte offsets and FSM encoding shared by packetizer and depacketizer
package rtp_pkg;
  localparam int RTP_HEADER_LENGTH = 12;
  localparam logic [1:0] RTP_VERSION = 2'd2;
  localparam int RTP_OFF_FLAGS = 0;
  localparam int RTP_OFF_PT = 1;
  localparam int RTP_OFF_SEQ = 2;
  localparam int RTP_OFF_TS = 4;
  localparam int RTP_OFF_SSRC = 8;
  typedef enum logic [1:0] {IDLE, HDR, PAY, DRAIN} rtp_state_e;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return &v ? v : v + 16'd1;
  endfunction
  function automatic logic [7:0] hdr_byte(input logic [8*RTP_HEADER_LENGTH-1:0] h, input int i);
    return h[8*(RTP_HEADER_LENGTH-1-i) +: 8];
  endfunction
endpackage

// File: rtl/rtp_sample_fifo.sv
// rtp_sample_fifo: synchronous first-word-fall-through FIFO of 16-bit samples
// Ports: rgmii_clk/rstn clock and sync active-low reset; wr_en/wr_data push;
// rd_en pop; rd_data head word; full/empty flags.
// A push while full is taken only if a pop frees the slot in the same cycle.
module rtp_sample_fifo #(
  parameter int FIFO_DEPTH = 1024
) (
  input  logic        rgmii_clk,
  input  logic        rstn,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        rd_en,
  output logic [15:0] rd_data,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [15:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wp_q, rp_q;
  logic do_rd, do_wr;
  assign empty = wp_q == rp_q;
  assign full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign rd_data = mem_q[rp_q[AW-1:0]];
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);
  always_ff @(posedge rgmii_clk) begin
    if (!rstn) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (do_wr) wp_q <= wp_q + 1'b1;
      if (do_rd) rp_q <= rp_q + 1'b1;
    end
  end
  always_ff @(posedge rgmii_clk) begin
    if (do_wr) mem_q[wp_q[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/rtp_depacketizer.sv
// rtp_depacketizer: validates and strips RTP headers, delivers big-endian 16-bit PCM samples via a FIFO
// Ports: rgmii_clk/rstn clock and sync active-low reset; udp_rec_* incoming
// UDP payload bytes with packet length; sample_* FWFT sample stream to the
// codec; pkt_ok/pkt_drop/seq_gap one-cycle event pulses; last_seq/last_ts
// fields of the last accepted header; drop/gap/ovf saturating counters.
// Build option: define RTP_SSRC_CHECK_EN to also require ssrc == SSRC.
module rtp_depacketizer
  import rtp_pkg::*;
#(
  parameter logic [6:0]  PT_EXPECT  = 7'd0,
  parameter logic [31:0] SSRC       = 32'h12345678,
  parameter int          FIFO_DEPTH = 1024
) (
  input  logic        rgmii_clk,
  input  logic        rstn,
  input  logic        udp_rec_data_valid,
  input  logic [7:0]  udp_rec_rdata,
  input  logic [15:0] udp_rec_data_length,
  output logic [15:0] sample_data,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        pkt_ok,
  output logic        pkt_drop,
  output logic        seq_gap,
  output logic [15:0] last_seq,
  output logic [31:0] last_ts,
  output logic [15:0] drop_cnt,
  output logic [15:0] gap_cnt,
  output logic [15:0] ovf_cnt
);
  rtp_state_e state_q;
  logic [15:0] len_q, cnt_q;
  logic [8*RTP_HEADER_LENGTH-9:0] hdr_q;
  logic [8*RTP_HEADER_LENGTH-1:0] hdr_w;
  logic [7:0] msb_q, b0_w, b1_w;
  logic [15:0] wr_data_q, seq_w;
  logic [31:0] ts_w, ssrc_w;
  logic wr_q, have_ref_q, hdr_ok_w, gap_w, fifo_full, fifo_empty, ovf_w;
  // hdr_q holds the previous 11 bytes, so at byte 11 the whole header is visible combinationally
  assign hdr_w = {hdr_q, udp_rec_rdata};
  assign b0_w = hdr_byte(hdr_w, RTP_OFF_FLAGS);
  assign b1_w = hdr_byte(hdr_w, RTP_OFF_PT);
  assign seq_w = {hdr_byte(hdr_w, RTP_OFF_SEQ), hdr_byte(hdr_w, RTP_OFF_SEQ + 1)};
  assign ts_w = {hdr_byte(hdr_w, RTP_OFF_TS), hdr_byte(hdr_w, RTP_OFF_TS + 1),
                 hdr_byte(hdr_w, RTP_OFF_TS + 2), hdr_byte(hdr_w, RTP_OFF_TS + 3)};
  assign ssrc_w = {hdr_byte(hdr_w, RTP_OFF_SSRC), hdr_byte(hdr_w, RTP_OFF_SSRC + 1),
                   hdr_byte(hdr_w, RTP_OFF_SSRC + 2), hdr_byte(hdr_w, RTP_OFF_SSRC + 3)};
`ifdef RTP_SSRC_CHECK_EN
  assign hdr_ok_w = b0_w[7:6] == RTP_VERSION && !b0_w[4] && b0_w[3:0] == 4'd0 &&
                    b1_w[6:0] == PT_EXPECT && ssrc_w == SSRC;
  logic unused_bits;
  assign unused_bits = ^{b0_w[5], b1_w[7]};
`else
  assign hdr_ok_w = b0_w[7:6] == RTP_VERSION && !b0_w[4] && b0_w[3:0] == 4'd0 &&
                    b1_w[6:0] == PT_EXPECT;
  logic unused_bits;
  assign unused_bits = ^{b0_w[5], b1_w[7], ssrc_w, SSRC};
`endif
  assign gap_w = have_ref_q && seq_w != last_seq + 16'd1;
  // full implies non-empty, so a ready consumer always frees a slot this cycle
  assign ovf_w = wr_q & fifo_full & ~sample_ready;
  assign sample_valid = ~fifo_empty;
  always_ff @(posedge rgmii_clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      len_q <= '0;
      cnt_q <= '0;
      hdr_q <= '0;
      msb_q <= '0;
      wr_q <= 1'b0;
      wr_data_q <= '0;
      have_ref_q <= 1'b0;
      pkt_ok <= 1'b0;
      pkt_drop <= 1'b0;
      seq_gap <= 1'b0;
      last_seq <= '0;
      last_ts <= '0;
      drop_cnt <= '0;
      gap_cnt <= '0;
      ovf_cnt <= '0;
    end else begin
      pkt_ok <= 1'b0;
      pkt_drop <= 1'b0;
      seq_gap <= 1'b0;
      wr_q <= 1'b0;
      if (ovf_w) ovf_cnt <= sat_inc(ovf_cnt);
      case (state_q)
        IDLE: if (udp_rec_data_valid) begin
          len_q <= udp_rec_data_length;
          cnt_q <= 16'd1;
          hdr_q <= hdr_w[8*RTP_HEADER_LENGTH-9:0];
          if (udp_rec_data_length < 16'(RTP_HEADER_LENGTH)) begin
            pkt_drop <= 1'b1;
            drop_cnt <= sat_inc(drop_cnt);
            state_q <= DRAIN;
          end else state_q <= HDR;
        end
        HDR: if (!udp_rec_data_valid) begin
          pkt_drop <= 1'b1;
          drop_cnt <= sat_inc(drop_cnt);
          state_q <= IDLE;
        end else begin
          cnt_q <= cnt_q + 16'd1;
          hdr_q <= hdr_w[8*RTP_HEADER_LENGTH-9:0];
          if (cnt_q == 16'(RTP_HEADER_LENGTH - 1)) begin
            if (!hdr_ok_w) begin
              pkt_drop <= 1'b1;
              drop_cnt <= sat_inc(drop_cnt);
              state_q <= DRAIN;
            end else begin
              last_seq <= seq_w;
              last_ts <= ts_w;
              have_ref_q <= 1'b1;
              if (gap_w) begin
                seq_gap <= 1'b1;
                gap_cnt <= sat_inc(gap_cnt);
              end
              pkt_ok <= len_q == 16'(RTP_HEADER_LENGTH);
              state_q <= len_q == 16'(RTP_HEADER_LENGTH) ? DRAIN : PAY;
            end
          end
        end
        PAY: if (!udp_rec_data_valid) begin
          pkt_drop <= 1'b1;
          drop_cnt <= sat_inc(drop_cnt);
          state_q <= IDLE;
        end else begin
          cnt_q <= cnt_q + 16'd1;
          // header length is even, so byte count parity gives payload byte parity
          if (!cnt_q[0]) msb_q <= udp_rec_rdata;
          else begin
            wr_q <= 1'b1;
            wr_data_q <= {msb_q, udp_rec_rdata};
          end
          if (cnt_q == len_q - 16'd1) begin
            pkt_ok <= 1'b1;
            state_q <= DRAIN;
          end
        end
        DRAIN: if (!udp_rec_data_valid) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  rtp_sample_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .rgmii_clk(rgmii_clk),
    .rstn(rstn),
    .wr_en(wr_q),
    .wr_data(wr_data_q),
    .rd_en(sample_ready),
    .rd_data(sample_data),
    .full(fifo_full),
    .empty(fifo_empty)
  );
endmodule

// File: tb/tb_rtp_depacketizer.sv
// tb_rtp_depacketizer: directed packets with a sample scoreboard and event-pulse counters
module tb_rtp_depacketizer;
  logic clk = 1'b0, rstn = 1'b0, valid = 1'b0, ready = 1'b1;
  logic [7:0] rdata = '0;
  logic [15:0] dlen = '0;
  logic [15:0] sample_data, last_seq, drop_cnt, gap_cnt, ovf_cnt;
  logic [31:0] last_ts;
  logic sample_valid, pkt_ok, pkt_drop, seq_gap;
  int checks = 0, errors = 0, n_ok = 0, n_drop = 0, n_gap = 0;
  logic [15:0] exp_q[$];
  logic [7:0] pkt[$];
  always #5 clk = ~clk;
  rtp_depacketizer #(.PT_EXPECT(7'd0), .SSRC(32'h12345678), .FIFO_DEPTH(16)) dut (
    .rgmii_clk(clk), .rstn(rstn), .udp_rec_data_valid(valid), .udp_rec_rdata(rdata),
    .udp_rec_data_length(dlen), .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(ready), .pkt_ok(pkt_ok), .pkt_drop(pkt_drop), .seq_gap(seq_gap),
    .last_seq(last_seq), .last_ts(last_ts), .drop_cnt(drop_cnt), .gap_cnt(gap_cnt),
    .ovf_cnt(ovf_cnt)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (pkt_ok) n_ok++;
    if (pkt_drop) n_drop++;
    if (seq_gap) n_gap++;
    if (sample_valid && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sample: got %0h expected none", sample_data);
      end else chk("sample", {16'd0, sample_data}, {16'd0, exp_q.pop_front()});
    end
  end
  task automatic do_reset();
    rstn = 1'b0;
    valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_q.delete();
    n_ok = 0;
    n_drop = 0;
    n_gap = 0;
  endtask
  task automatic build(input logic [7:0] b0, input logic [15:0] seq, input logic [31:0] ts,
                       input logic [31:0] ssrc, input int len, input logic [15:0] base);
    logic [15:0] s;
    pkt.delete();
    pkt.push_back(b0);
    pkt.push_back(8'h00);
    pkt.push_back(seq[15:8]);
    pkt.push_back(seq[7:0]);
    for (int i = 3; i >= 0; i--) pkt.push_back(ts[8*i +: 8]);
    for (int i = 3; i >= 0; i--) pkt.push_back(ssrc[8*i +: 8]);
    for (int i = 0; i < len - 12; i++) begin
      s = base + 16'(i / 2);
      pkt.push_back(i % 2 == 0 ? s[15:8] : s[7:0]);
    end
  endtask
  task automatic expect_samples(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 16'(i));
  endtask
  task automatic send(input int n, input int len, input bit drop_valid);
    for (int i = 0; i < n; i++) begin
      valid = 1'b1;
      rdata = pkt[i];
      dlen = 16'(len);
      @(posedge clk);
      #1;
    end
    if (drop_valid) begin
      valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask
  task automatic drain(input string name);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1;
    chk(name, exp_q.size(), 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    do_reset();
    chk("rst_valid", {31'd0, sample_valid}, 0);
    chk("rst_seq", {16'd0, last_seq}, 0);
    chk("rst_ts", last_ts, 0);
    chk("rst_cnts", {drop_cnt, gap_cnt | ovf_cnt}, 0);
    // full-size packet, seq 5, 480 samples 0x0001..0x01E0
    build(8'h80, 16'h0005, 32'hCAFE0001, 32'h12345678, 972, 16'h0001);
    expect_samples(16'h0001, 480);
    send(972, 972, 1'b1);
    drain("drain_full");
    chk("full_ok", n_ok, 1);
    chk("full_drop", n_drop, 0);
    chk("full_gap", n_gap, 0);
    chk("full_seq", {16'd0, last_seq}, 16'h0005);
    chk("full_ts", last_ts, 32'hCAFE0001);
    // sequence wrap is continuous, skip is a gap
    do_reset();
    build(8'h80, 16'hFFFF, 32'h1, 32'h12345678, 16, 16'h0010);
    expect_samples(16'h0010, 2);
    send(16, 16, 1'b1);
    build(8'h80, 16'h0000, 32'h2, 32'h12345678, 16, 16'h0020);
    expect_samples(16'h0020, 2);
    send(16, 16, 1'b1);
    drain("drain_wrap");
    chk("wrap_gap", n_gap, 0);
    build(8'h80, 16'h0002, 32'h3, 32'h12345678, 16, 16'h0030);
    expect_samples(16'h0030, 2);
    send(16, 16, 1'b1);
    drain("drain_skip");
    chk("skip_gap", n_gap, 1);
    chk("skip_gapcnt", {16'd0, gap_cnt}, 1);
    chk("skip_ok", n_ok, 3);
    chk("skip_seq", {16'd0, last_seq}, 16'h0002);
    // bad version is dropped, no samples, last_seq kept
    do_reset();
    build(8'h80, 16'h0007, 32'h7, 32'h12345678, 14, 16'h0700);
    expect_samples(16'h0700, 1);
    send(14, 14, 1'b1);
    build(8'h40, 16'h0009, 32'h9, 32'h12345678, 20, 16'h0800);
    send(20, 20, 1'b1);
    drain("drain_ver");
    chk("ver_drop", n_drop, 1);
    chk("ver_dropcnt", {16'd0, drop_cnt}, 1);
    chk("ver_seq", {16'd0, last_seq}, 16'h0007);
    chk("ver_ok", n_ok, 1);
    // truncation after 100 of 972 bytes leaves 44 samples, next packet still accepted
    do_reset();
    build(8'h80, 16'h0005, 32'h5, 32'h12345678, 972, 16'h0001);
    expect_samples(16'h0001, 44);
    send(100, 972, 1'b1);
    drain("drain_trunc");
    chk("trunc_drop", n_drop, 1);
    chk("trunc_ok", n_ok, 0);
    build(8'h80, 16'h0006, 32'h6, 32'h12345678, 16, 16'h0300);
    expect_samples(16'h0300, 2);
    send(16, 16, 1'b1);
    drain("drain_after_trunc");
    chk("trunc_next_ok", n_ok, 1);
    chk("trunc_next_seq", {16'd0, last_seq}, 16'h0006);
    chk("trunc_dropcnt", {16'd0, drop_cnt}, 1);
    // consumer stalled: 40 samples into a 16-deep FIFO
    do_reset();
    ready = 1'b0;
    build(8'h80, 16'h0010, 32'h10, 32'h12345678, 92, 16'h0200);
    expect_samples(16'h0200, 16);
    send(92, 92, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("ovf_cnt", {16'd0, ovf_cnt}, 24);
    chk("ovf_ok", n_ok, 1);
    chk("ovf_valid", {31'd0, sample_valid}, 1);
    ready = 1'b1;
    drain("drain_ovf");
    // ssrc mismatch: rejected only when the check is built in
    do_reset();
    build(8'h80, 16'h0040, 32'h40, 32'hDEADBEEF, 16, 16'h0400);
`ifdef RTP_SSRC_CHECK_EN
    send(16, 16, 1'b1);
    drain("drain_ssrc");
    chk("ssrc_drop", n_drop, 1);
    chk("ssrc_ok", n_ok, 0);
`else
    expect_samples(16'h0400, 2);
    send(16, 16, 1'b1);
    drain("drain_ssrc");
    chk("ssrc_drop", n_drop, 0);
    chk("ssrc_ok", n_ok, 1);
`endif
    // short length, header-only packet, odd trailing byte
    do_reset();
    build(8'h80, 16'h001F, 32'h1F, 32'h12345678, 12, 16'h0);
    send(8, 8, 1'b1);
    build(8'h80, 16'h0020, 32'h20, 32'h12345678, 12, 16'h0);
    send(12, 12, 1'b1);
    build(8'h80, 16'h0021, 32'h21, 32'h12345678, 15, 16'h0500);
    expect_samples(16'h0500, 1);
    send(15, 15, 1'b1);
    drain("drain_len");
    chk("len_ok", n_ok, 2);
    chk("len_dropcnt", {16'd0, drop_cnt}, 1);
    chk("len_seq", {16'd0, last_seq}, 16'h0021);
    // reset mid-packet: no pulses, FIFO flushed
    do_reset();
    ready = 1'b0;
    build(8'h80, 16'h0030, 32'h30, 32'h12345678, 40, 16'h0900);
    send(20, 40, 1'b0);
    rstn = 1'b0;
    valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_pulses", n_ok + n_drop + n_gap, 0);
    chk("mid_valid", {31'd0, sample_valid}, 0);
    chk("mid_seq", {16'd0, last_seq}, 0);
    ready = 1'b1;
    build(8'h80, 16'h0031, 32'h31, 32'h12345678, 16, 16'h0600);
    expect_samples(16'h0600, 2);
    send(16, 16, 1'b1);
    drain("drain_mid");
    chk("mid_next_ok", n_ok, 1);
    chk("mid_next_seq", {16'd0, last_seq}, 16'h0031);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rtp_depacketizer.md
# rtp_depacketizer

Receive-side RTP stage for the wm8731 audio-over-Ethernet path. Consumes the UDP payload byte stream delivered by the UDP receive engine, validates and strips the 12-byte RTP header, tracks sequence-number continuity, and delivers big-endian 16-bit PCM samples through an internal FIFO to the codec playback path. It is the receive-side counterpart of the RTP packetizer feeding the UDP transmit engine.

## Interface
- PT_EXPECT, 7'd0: required RTP payload type.
- SSRC, 32'h12345678: expected stream source id; used only with the SSRC check macro.
- FIFO_DEPTH, 1024: sample FIFO depth in 16-bit words; power of two, ≥ 16.
- rgmii_clk  in  1  clock; all logic single-domain on its rising edge.
- rstn  in  1  reset, synchronous, active-low.
- udp_rec_data_valid  in  1  byte strobe; high for every byte of a packet, low ≥ 1 cycle between packets.
- udp_rec_rdata  in  8  payload byte, RTP byte 0 first.
- udp_rec_data_length  in  16  packet byte count (RTP header + payload); stable while valid.
- sample_data  out  16  PCM sample at FIFO head.
- sample_valid  out  1  FIFO non-empty.
- sample_ready  in  1  consumer pop; pop occurs when valid & ready.
- pkt_ok  out  1  one-cycle pulse: packet fully received and accepted.
- pkt_drop  out  1  one-cycle pulse: packet rejected or truncated.
- seq_gap  out  1  one-cycle pulse: sequence discontinuity.
- last_seq  out  16  sequence number of last accepted header.
- last_ts  out  32  timestamp of last accepted header.
- drop_cnt, gap_cnt, ovf_cnt  out  16 each  saturating event counters.

## Operation
- FSM states IDLE, HDR, PAY, DRAIN; reset → IDLE.
- IDLE: on valid, latch udp_rec_data_length into len, byte_cnt←1, capture byte 0, → HDR. If len < 12 → DRAIN with pkt_drop.
- HDR: capture bytes 1–11 (seq bytes 2–3, ts 4–7, ssrc 8–11, big-endian). At byte 11 evaluate: V==2, X==0, CC==0, PT==PT_EXPECT (marker and padding bits ignored). Fail → pkt_drop, drop_cnt++, → DRAIN. Pass → update last_seq/last_ts; → PAY, or → DRAIN with pkt_ok if len == 12.
- Sequence check on pass: first accepted packet after reset sets reference, no gap. Thereafter if seq ≠ (prev_seq+1) mod 2^16 → seq_gap, gap_cnt++. Wrap 0xFFFF→0x0000 is continuous. Packet is still accepted.
- PAY: even payload byte = sample MSB held; odd byte completes sample {msb, byte} and writes FIFO. Odd trailing byte discarded. When byte_cnt reaches len → pkt_ok, → DRAIN.
- FIFO full on write: sample discarded, ovf_cnt++; packet still completes normally.
- DRAIN: ignore bytes until valid low → IDLE.
- Valid low in HDR or PAY before len bytes: truncation → pkt_drop, drop_cnt++, → IDLE; samples already written stay in FIFO.
- Counters saturate at 16'hFFFF; cleared only by reset.
- Simultaneous FIFO write and pop when full: write accepted (pop frees slot same cycle).

## Timing
- All outputs reset to 0; FIFO empties on reset; reset mid-packet discards packet with no pulses.
- Header fields, pkt_drop, seq_gap valid the cycle after byte 11 is sampled.
- Sample written to FIFO the cycle after its LSB byte; sample_valid high the following cycle (2-cycle byte-to-output latency, first-word fall-through).
- pkt_ok one cycle after final byte.
- Input has no backpressure; block accepts one byte per cycle continuously.

## Configuration
- RTP_SSRC_CHECK_EN defined: header additionally requires ssrc == SSRC; mismatch → pkt_drop, drop_cnt++, no sequence update.
- Undefined: SSRC bytes captured but ignored; no comparator synthesized.

## Structure
- Shared package rtp_pkg: RTP_HEADER_LENGTH = 12, RTP_VERSION = 2, header byte offsets, FSM state encoding; shared with the packetizer.
- Sub-module rtp_sample_fifo: synchronous first-word-fall-through FIFO, parameter FIFO_DEPTH, full/empty flags, 16-bit data.

## Test plan
- 972-byte packet, header 80 00 00 05 …, SSRC 12345678, samples 0x0001..0x01E0 → 480 samples in order, pkt_ok once, last_seq 5.
- Packets seq 0xFFFF then 0x0000 then 0x0002 → single seq_gap on third, gap_cnt 1.
- Header byte 0 = 0x40 (V=1) → pkt_drop, drop_cnt 1, no samples, last_seq unchanged.
- Valid drops after 100 bytes of 972 → pkt_drop, 44 samples in FIFO, FSM in IDLE; next good packet accepted.
- sample_ready low, FIFO_DEPTH 16, 40-sample packet → 16 samples held, ovf_cnt 24, pkt_ok asserted.
- With RTP_SSRC_CHECK_EN, SSRC 0xDEADBEEF → pkt_drop; without macro same packet → pkt_ok.
